// File: rtl/fpu_requester.sv
// Issue-side FPU controller: accepts one FP request at a time, drives the
// FPU ctl/x1/x2/en handshake, waits for the single-cycle ready pulse and
// presents a one-cycle tagged register writeback.
// Optional watchdog on a missing ready: define FPU_REQ_WATCHDOG_EN.
module fpu_requester #(
  parameter int unsigned TIMEOUT = 12  // cycles in WAIT before error writeback (8..31)
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_ctl,
  input  logic [31:0] req_x1,
  input  logic [31:0] req_x2,
  input  logic [5:0]  req_rd,
  output logic [4:0]  fpu_ctl,
  output logic [31:0] fpu_x1,
  output logic [31:0] fpu_x2,
  output logic        fpu_en,
  input  logic        fpu_ready,
  input  logic [31:0] fpu_y,
  output logic        wb_valid,
  output logic [5:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_int,
  output logic        wb_err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [4:0] MaxCtl = 5'd18;

  state_e      state_q, state_d;
  logic [4:0]  ctl_q;
  logic [31:0] x1_q, x2_q;
  logic [5:0]  rd_q;
  logic [31:0] data_q;
  logic        err_q;
  logic        accept;
  logic        illegal;
  logic        timeout;
  logic        ctl_is_int;

  assign accept  = (state_q == StIdle) && req_valid;
  assign illegal = req_ctl > MaxCtl;

`ifdef FPU_REQ_WATCHDOG_EN
  localparam logic [4:0] TimeoutLast = 5'(TIMEOUT - 1);

  logic [4:0] cnt_q;

  // Watchdog: cleared on issue, counts every WAIT cycle without ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= 5'd0;
    end else if (state_q == StIssue) begin
      cnt_q <= 5'd0;
    end else if (state_q == StWait) begin
      cnt_q <= cnt_q + 5'd1;
    end
  end

  // Ready in the last WAIT cycle takes priority over the timeout.
  assign timeout = (state_q == StWait) && !fpu_ready && (cnt_q == TimeoutLast);
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = illegal ? StDone : StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (fpu_ready || timeout) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch: operands and opcode held stable for the whole operation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctl_q <= 5'd0;
      x1_q  <= 32'd0;
      x2_q  <= 32'd0;
      rd_q  <= 6'd0;
    end else if (accept) begin
      ctl_q <= req_ctl;
      x1_q  <= req_x1;
      x2_q  <= req_x2;
      rd_q  <= req_rd;
    end
  end

  // Result register: zeroed on accept, loaded from the FPU on ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= 32'd0;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= 32'd0;
      err_q  <= illegal;
    end else if ((state_q == StWait) && fpu_ready) begin
      data_q <= fpu_y;
      err_q  <= 1'b0;
    end else if (timeout) begin
      data_q <= 32'd0;
      err_q  <= 1'b1;
    end
  end

  // Ops that write the integer file: compares, classify and int conversions/moves.
  always_comb begin
    ctl_is_int = 1'b0;
    case (ctl_q)
      5'd9, 5'd10, 5'd13, 5'd14, 5'd15, 5'd16: ctl_is_int = 1'b1;
      default:                                 ctl_is_int = 1'b0;
    endcase
  end

  // Outputs; writeback fields are only non-zero while the strobe is up.
  always_comb begin
    req_ready = (state_q == StIdle);
    fpu_en    = (state_q == StIssue);
    fpu_ctl   = ctl_q;
    fpu_x1    = x1_q;
    fpu_x2    = x2_q;
    wb_valid  = (state_q == StDone);
    wb_rd     = wb_valid ? rd_q : 6'd0;
    wb_data   = wb_valid ? data_q : 32'd0;
    wb_int    = wb_valid && ctl_is_int;
    wb_err    = wb_valid && err_q;
  end

endmodule

// File: tb/tb_fpu_requester.sv
// Directed self-checking bench for fpu_requester. The FPU is modelled by
// the stimulus itself: ready/y are driven at hand-chosen cycles.
module tb_fpu_requester;

  logic        clk;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_ctl;
  logic [31:0] req_x1;
  logic [31:0] req_x2;
  logic [5:0]  req_rd;
  logic [4:0]  fpu_ctl;
  logic [31:0] fpu_x1;
  logic [31:0] fpu_x2;
  logic        fpu_en;
  logic        fpu_ready;
  logic [31:0] fpu_y;
  logic        wb_valid;
  logic [5:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_int;
  logic        wb_err;

  int n_assert = 0;
  int n_fail   = 0;

  fpu_requester #(.TIMEOUT(12)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_ctl   (req_ctl),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .req_rd    (req_rd),
    .fpu_ctl   (fpu_ctl),
    .fpu_x1    (fpu_x1),
    .fpu_x2    (fpu_x2),
    .fpu_en    (fpu_en),
    .fpu_ready (fpu_ready),
    .fpu_y     (fpu_y),
    .wb_valid  (wb_valid),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_int    (wb_int),
    .wb_err    (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current (idle) cycle; returns in cycle A+1.
  task automatic accept(input logic [4:0] ctl, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [5:0] rd);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1;
    req_ctl   = ctl;
    req_x1    = x1;
    req_x2    = x2;
    req_rd    = rd;
    step();
    // Scramble the request bus to prove the block uses its latched copy.
    req_valid = 1'b0;
    req_ctl   = 5'd3;
    req_x1    = ~x1;
    req_x2    = ~x2;
    req_rd    = ~rd;
  endtask

  // Full legal op with an N-stage FPU returning y.
  task automatic run_op(input string name, input logic [4:0] ctl, input logic [31:0] x1,
                        input logic [31:0] x2, input logic [5:0] rd, input int n,
                        input logic [31:0] y, input logic exp_int);
    accept(ctl, x1, x2, rd);
    chk({name, "_en_a1"}, fpu_en, 1);
    chk({name, "_ctl_a1"}, fpu_ctl, 32'(ctl));
    chk({name, "_x1_a1"}, fpu_x1, x1);
    chk({name, "_x2_a1"}, fpu_x2, x2);
    chk({name, "_req_ready_a1"}, req_ready, 0);
    for (int k = 2; k <= 2 + n; k++) begin
      step();
      chk($sformatf("%s_en_a%0d", name, k), fpu_en, 0);
      chk($sformatf("%s_ctl_a%0d", name, k), fpu_ctl, 32'(ctl));
      chk($sformatf("%s_x1_a%0d", name, k), fpu_x1, x1);
      chk($sformatf("%s_x2_a%0d", name, k), fpu_x2, x2);
      chk($sformatf("%s_wbv_a%0d", name, k), wb_valid, 0);
      chk($sformatf("%s_req_ready_a%0d", name, k), req_ready, 0);
      if (k == 2 + n) begin
        fpu_ready = 1'b1;
        fpu_y     = y;
      end
    end
    step();
    fpu_ready = 1'b0;
    fpu_y     = 32'hDEAD_BEEF;
    chk({name, "_wb_valid"}, wb_valid, 1);
    chk({name, "_wb_rd"}, wb_rd, 32'(rd));
    chk({name, "_wb_data"}, wb_data, y);
    chk({name, "_wb_int"}, wb_int, 32'(exp_int));
    chk({name, "_wb_err"}, wb_err, 0);
    chk({name, "_req_ready_wb"}, req_ready, 0);
    step();
    chk({name, "_wb_valid_after"}, wb_valid, 0);
    chk({name, "_req_ready_after"}, req_ready, 1);
  endtask

  initial begin
    logic saw_wb;
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_ctl   = 5'd0;
    req_x1    = 32'd0;
    req_x2    = 32'd0;
    req_rd    = 6'd0;
    fpu_ready = 1'b0;
    fpu_y     = 32'hDEAD_BEEF;

    // Reset state.
    #2;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_fpu_en", fpu_en, 0);
    chk("rst_fpu_ctl", fpu_ctl, 0);
    chk("rst_fpu_x1", fpu_x1, 0);
    chk("rst_fpu_x2", fpu_x2, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_int", wb_int, 0);
    chk("rst_wb_err", wb_err, 0);
    step();
    #2 rstn = 1'b1;
    step();
    chk("post_rst_idle", req_ready, 1);

    // fadd 1.0 + 2.0 = 3.0, one FPU stage: writeback at A+4.
    run_op("fadd", 5'd0, 32'h3F80_0000, 32'h4000_0000, 6'd5, 1, 32'h4040_0000, 1'b0);
    // fle -1.0 <= 1.0, combinational compare: writeback at A+3, integer file.
    run_op("fle", 5'd10, 32'hBF80_0000, 32'h3F80_0000, 6'd7, 0, 32'h0000_0001, 1'b1);
    // fdiv 6.0 / 2.0 = 3.0, six stages: writeback at A+9, ready back at A+10.
    run_op("fdiv", 5'd4, 32'h40C0_0000, 32'h4000_0000, 6'd33, 6, 32'h4040_0000, 1'b0);
    // Integer-file op (ctl 13) and last legal opcode (18, FP file).
    run_op("fcvtw", 5'd13, 32'h4120_0000, 32'h0000_0000, 6'd63, 2, 32'h0000_000A, 1'b1);
    run_op("op18", 5'd18, 32'h1234_5678, 32'h9ABC_DEF0, 6'd1, 1, 32'h0BAD_F00D, 1'b0);

    // Illegal opcode: FPU untouched, error writeback at A+1.
    accept(5'd25, 32'h1111_1111, 32'h2222_2222, 6'd9);
    chk("ill_fpu_en_a1", fpu_en, 0);
    chk("ill_wb_valid", wb_valid, 1);
    chk("ill_wb_err", wb_err, 1);
    chk("ill_wb_data", wb_data, 0);
    chk("ill_wb_rd", wb_rd, 9);
    chk("ill_wb_int", wb_int, 0);
    step();
    chk("ill_fpu_en_a2", fpu_en, 0);
    chk("ill_wb_valid_after", wb_valid, 0);
    chk("ill_req_ready_after", req_ready, 1);
    // ctl 19 is the first illegal value.
    accept(5'd19, 32'h0, 32'h0, 6'd2);
    chk("ill19_fpu_en", fpu_en, 0);
    chk("ill19_wb_err", wb_err, 1);
    step();

`ifdef FPU_REQ_WATCHDOG_EN
    // Missing ready: WAIT entered at A+2, error writeback at A+14.
    accept(5'd2, 32'h4000_0000, 32'h4000_0000, 6'd11);
    chk("wd_en_a1", fpu_en, 1);
    for (int k = 2; k <= 13; k++) begin
      step();
      chk($sformatf("wd_wbv_a%0d", k), wb_valid, 0);
      chk($sformatf("wd_en_a%0d", k), fpu_en, 0);
    end
    step();
    chk("wd_wb_valid", wb_valid, 1);
    chk("wd_wb_err", wb_err, 1);
    chk("wd_wb_data", wb_data, 0);
    chk("wd_wb_rd", wb_rd, 11);
    step();
    chk("wd_req_ready_after", req_ready, 1);
    // Stray ready in IDLE is ignored.
    fpu_ready = 1'b1;
    fpu_y     = 32'h5555_AAAA;
    step();
    fpu_ready = 1'b0;
    chk("stray_req_ready", req_ready, 1);
    chk("stray_wb_valid", wb_valid, 0);
    chk("stray_fpu_en", fpu_en, 0);
    step();
    chk("stray_wb_valid2", wb_valid, 0);
    chk("stray_req_ready2", req_ready, 1);

    // Ready in the last WAIT cycle beats the timeout.
    accept(5'd2, 32'h4000_0000, 32'h4000_0000, 6'd12);
    for (int k = 2; k <= 13; k++) begin
      step();
      chk($sformatf("wdr_wbv_a%0d", k), wb_valid, 0);
      if (k == 13) begin
        fpu_ready = 1'b1;
        fpu_y     = 32'h4080_0000;
      end
    end
    step();
    fpu_ready = 1'b0;
    fpu_y     = 32'hDEAD_BEEF;
    chk("wdr_wb_valid", wb_valid, 1);
    chk("wdr_wb_err", wb_err, 0);
    chk("wdr_wb_data", wb_data, 32'h4080_0000);
    step();
`else
    // Without the watchdog, WAIT holds until ready however late it is.
    accept(5'd2, 32'h4000_0000, 32'h4000_0000, 6'd11);
    saw_wb = 1'b0;
    for (int k = 2; k <= 40; k++) begin
      step();
      if (wb_valid !== 1'b0 || req_ready !== 1'b0) saw_wb = 1'b1;
    end
    chk("nowd_no_early_wb", saw_wb, 0);
    fpu_ready = 1'b1;
    fpu_y     = 32'h4080_0000;
    step();
    fpu_ready = 1'b0;
    fpu_y     = 32'hDEAD_BEEF;
    chk("nowd_wb_valid", wb_valid, 1);
    chk("nowd_wb_err", wb_err, 0);
    chk("nowd_wb_data", wb_data, 32'h4080_0000);
    step();
    chk("nowd_req_ready_after", req_ready, 1);
`endif

    // Reset during WAIT of an fdiv: immediate abort, no writeback afterwards.
    accept(5'd4, 32'h40C0_0000, 32'h4000_0000, 6'd20);
    step();
    step();
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_fpu_en", fpu_en, 0);
    chk("mid_rst_fpu_ctl", fpu_ctl, 0);
    chk("mid_rst_fpu_x1", fpu_x1, 0);
    chk("mid_rst_fpu_x2", fpu_x2, 0);
    chk("mid_rst_wb_valid", wb_valid, 0);
    chk("mid_rst_wb_data", wb_data, 0);
    #1 rstn = 1'b1;
    saw_wb = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (wb_valid !== 1'b0 || fpu_en !== 1'b0) saw_wb = 1'b1;
    end
    chk("mid_rst_no_wb", saw_wb, 0);
    chk("mid_rst_idle", req_ready, 1);

    // Normal operation resumes after the abort.
    run_op("fsub", 5'd1, 32'h4040_0000, 32'h3F80_0000, 6'd3, 1, 32'h4000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Overall time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: observed simulation still running, expected completion");
    $fatal(1, "time limit");
  end

endmodule
